// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: takes 32-bit words over a valid/ready stream and
// writes each as four little-endian byte writes, holding the core in reset meanwhile.
module instr_mem_loader #(
  parameter int MEM_BYTES = 16,
  parameter int ADDR_W    = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FINISH} state_t;

  // Wide enough that base + 4*count can never wrap.
  localparam int CHK_W = ADDR_W + CNT_W + 2;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       word_q;
  logic [1:0]        idx_q;

  logic [CHK_W-1:0]  end_addr;
  logic              misaligned;
  logic              range_bad;

  assign end_addr   = CHK_W'(base_addr) + (CHK_W'(num_words) << 2);
  assign misaligned = base_addr[1:0] != 2'b00;
  assign range_bad  = end_addr > CHK_W'(MEM_BYTES);

  // NOTE: all state and outputs are assigned with <= so every register samples
  // the pre-edge values; mixing in blocking assignments would reorder the pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // Strobe is a one-cycle pulse; address and data hold their last values.
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            cnt_q  <= num_words;
            done   <= 1'b0;
            error  <= 1'b0;
            if (misaligned || range_bad) begin
              error <= 1'b1;
              state <= FINISH;
            end else if (num_words == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
              in_ready <= 1'b1;
              state    <= ACCEPT;
            end
          end
        end
        ACCEPT: begin
          if (in_valid && in_ready) begin
            word_q   <= in_word;
            idx_q    <= 2'd0;
            in_ready <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          mem_we    <= 1'b1;
          mem_addr  <= addr_q + ADDR_W'(idx_q);
          mem_wdata <= word_q[{idx_q, 3'b000} +: 8];
          idx_q     <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_q <= addr_q + ADDR_W'(4);
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              state    <= FINISH;
            end else begin
              in_ready <= 1'b1;
              state    <= ACCEPT;
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of load scenarios plus hand-written
// reset-mid-load sequence, checked against a byte-level shadow memory.
module tb_instr_mem_loader;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 16;
  localparam int BUDGET = 200;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_words;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              error;

  instr_mem_loader #(.MEM_BYTES(16), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] base;
    int          num;
    int          gap;      // idle cycles offered in ACCEPT between words
    int          busy_at;  // cycle at which a stray start is pulsed (0 = never)
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
    int          exp_cyc;  // cycles from start to done/error (0 = not checked)
    logic [63:0] lo;
    logic [63:0] hi;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Shadow memory and protocol monitors.
  logic [7:0]  mem_model [16];
  logic [63:0] lo = 64'd1, hi = 64'd0;
  int wr_cnt = 0, bad_cnt = 0, ready_viol = 0, both_cnt = 0, hold_cnt = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        wr_cnt <= wr_cnt + 1;
        if (mem_addr < 64'd16) mem_model[mem_addr[3:0]] <= mem_wdata;
        if (mem_addr < lo || mem_addr > hi) bad_cnt <= bad_cnt + 1;
      end
      if ((in_ready && mem_we && mem_addr[1:0] != 2'd3) || (in_ready && !busy))
        ready_viol <= ready_viol + 1;
      if (done && error) both_cnt <= both_cnt + 1;
      if (cpu_hold != busy) hold_cnt <= hold_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int vi, input int k);
    logic [31:0] w;
    logic [7:0]  b;
    case (k % 4)
      0: w = 32'h0285_3483;
      1: w = 32'h009A_84B3;
      2: w = 32'h0014_849A;
      default: w = 32'h0295_3423;
    endcase
    b = 8'(vi);
    return w ^ {4{b}};
  endfunction

  task automatic run_vec(input vec_t v, input int vi);
    int   cycles, fed, gap_cnt, wr0, bad0;
    logic hs;
    logic [31:0] w;
    lo   = v.lo;
    hi   = v.hi;
    wr0  = wr_cnt;
    bad0 = bad_cnt;
    @(negedge clk);
    base_addr = v.base;
    num_words = CNT_W'(v.num);
    start     = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cycles  = 1;
    fed     = 0;
    gap_cnt = 0;
    while (!(done || error) && cycles < BUDGET) begin
      start = (cycles == v.busy_at);
      if (start) begin
        base_addr = 64'd8;
        num_words = 16'd1;
      end
      if (fed < v.num && !(in_ready && gap_cnt > 0)) begin
        in_valid = 1'b1;
        in_word  = pat(vi, fed);
      end else begin
        in_valid = 1'b0;
      end
      if (in_ready && gap_cnt > 0) gap_cnt--;
      hs = in_valid && in_ready;
      @(negedge clk);
      cycles++;
      if (hs) begin
        fed++;
        gap_cnt = v.gap;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check($sformatf("v%0d timeout", vi), 64'(cycles < BUDGET), 64'd1);
    check($sformatf("v%0d done", vi), 64'(done), 64'(v.exp_done));
    check($sformatf("v%0d error", vi), 64'(error), 64'(v.exp_err));
    check($sformatf("v%0d cpu_hold", vi), 64'(cpu_hold), 64'd0);
    if (v.exp_cyc != 0)
      check($sformatf("v%0d cycles", vi), 64'(cycles), 64'(v.exp_cyc));
    @(negedge clk);
    @(negedge clk);
    check($sformatf("v%0d writes", vi), 64'(wr_cnt - wr0), 64'(v.exp_wr));
    check($sformatf("v%0d bad_addr", vi), 64'(bad_cnt - bad0), 64'd0);
    check($sformatf("v%0d words", vi), 64'(fed), 64'(v.exp_wr / 4));
    check($sformatf("v%0d sticky", vi), 64'({done, error}), 64'({v.exp_done, v.exp_err}));
    if (v.lo <= v.hi) begin
      for (logic [63:0] a = v.lo; a <= v.hi; a++) begin
        w = pat(vi, int'((a - v.lo) >> 2));
        check($sformatf("v%0d mem[%0d]", vi, a), 64'(mem_model[a[3:0]]),
              64'(w[8 * int'((a - v.lo) & 64'd3) +: 8]));
      end
    end
  endtask

  vec_t vecs [8];
  vec_t v_after;
  int   waited;

  initial begin
    //        base                     num gap bsy done err wr cyc lo     hi
    vecs[0] = '{64'd0,                  4, 0,  0, 1'b1, 1'b0, 16, 21, 64'd0,  64'd15};
    vecs[1] = '{64'd4,                  2, 3,  0, 1'b1, 1'b0,  8, 14, 64'd4,  64'd11};
    vecs[2] = '{64'd12,                 1, 0,  0, 1'b1, 1'b0,  4,  6, 64'd12, 64'd15};
    vecs[3] = '{64'd12,                 2, 0,  0, 1'b0, 1'b1,  0,  1, 64'd1,  64'd0};
    vecs[4] = '{64'd2,                  1, 0,  0, 1'b0, 1'b1,  0,  1, 64'd1,  64'd0};
    vecs[5] = '{64'd0,                  0, 0,  0, 1'b1, 1'b0,  0,  1, 64'd1,  64'd0};
    vecs[6] = '{64'd0,                  2, 0,  3, 1'b1, 1'b0,  8, 11, 64'd0,  64'd7};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 1'b0, 1'b1,  0,  1, 64'd1,  64'd0};

    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    in_valid  = 1'b0;
    in_word   = '0;
    #2;
    check("reset outputs",
          64'({in_ready, mem_we, busy, cpu_hold, done, error}), 64'd0);
    check("reset mem_addr", mem_addr, 64'd0);
    check("reset mem_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        check("normal mem[0]",  64'(mem_model[0]),  64'h83);
        check("normal mem[1]",  64'(mem_model[1]),  64'h34);
        check("normal mem[2]",  64'(mem_model[2]),  64'h85);
        check("normal mem[3]",  64'(mem_model[3]),  64'h02);
        check("normal mem[4]",  64'(mem_model[4]),  64'hB3);
        check("normal mem[15]", 64'(mem_model[15]), 64'h02);
      end
    end

    // Reset during the second byte write of the first word.
    lo = 64'd0;
    hi = 64'd7;
    @(negedge clk);
    base_addr = 64'd0;
    num_words = 16'd2;
    start     = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_word  = 32'hA1B2_C3D4;
    waited   = 0;
    while (!(mem_we && mem_addr == 64'd1) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("reset-mid wait", 64'(waited < 20), 64'd1);
    check("reset-mid byte1", 64'(mem_wdata), 64'hC3);
    #1 reset_n = 1'b0;
    #1;
    check("reset-mid outputs",
          64'({in_ready, mem_we, busy, cpu_hold, done, error}), 64'd0);
    check("reset-mid mem_addr", mem_addr, 64'd0);
    check("reset-mid mem_wdata", 64'(mem_wdata), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    v_after = '{64'd0, 4, 0, 0, 1'b1, 1'b0, 16, 21, 64'd0, 64'd15};
    run_vec(v_after, 9);

    check("in_ready outside ACCEPT", 64'(ready_viol), 64'd0);
    check("done and error together", 64'(both_cnt), 64'd0);
    check("cpu_hold equals busy", 64'(hold_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
